// File: rtl/shift_issue_stage_pkg.sv
// rtl/shift_issue_stage_pkg.sv - shared op-code enum and queued command type for the shift issue stage
package shift_issue_stage_pkg;

  localparam int CMD_DATA_WIDTH = 32;
  localparam int CMD_SFT_WIDTH  = 5;
  localparam int CMD_TAG_WIDTH  = 4;

  typedef enum logic [1:0] {
    SFT_SRL = 2'b00,
    SFT_SRA = 2'b01,
    SFT_SLL = 2'b10,
    SFT_ROR = 2'b11
  } sft_op_e;

  typedef struct packed {
    sft_op_e                   op;
    logic [CMD_DATA_WIDTH-1:0] dat;
    logic [CMD_SFT_WIDTH-1:0]  sftBit;
    logic [CMD_TAG_WIDTH-1:0]  tag;
  } shift_cmd_t;

endpackage

// File: rtl/shift_cmd_fifo.sv
// rtl/shift_cmd_fifo.sv - command queue with push/pop, full/empty and occupancy count
import shift_issue_stage_pkg::*;

module shift_cmd_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  shift_cmd_t   push_cmd,
  input  logic         pop,
  output shift_cmd_t   head_cmd,
  output logic         full,
  output logic         empty,
  output logic [PTR_W:0] count
);

  shift_cmd_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_cmd = mem[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap to 0
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr_q] <= push_cmd;
  end

endmodule

// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - queued shift unit: command FIFO, barrel shift of the head, registered result
import shift_issue_stage_pkg::*;

module shift_issue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int SFT_WIDTH  = 5,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iFlush,
  input  logic                     iVld,
  output logic                     oRdy,
  input  logic [1:0]               iOp,
  input  logic [DATA_WIDTH-1:0]    iDat,
  input  logic [SFT_WIDTH-1:0]     iSftBit,
  input  logic [TAG_WIDTH-1:0]     iTag,
  output logic                     oVld,
  input  logic                     iRdy,
  output logic [DATA_WIDTH-1:0]    oDat,
  output logic [TAG_WIDTH-1:0]     oTag,
  output logic [$clog2(DEPTH):0]   oCnt
);

  if (SFT_WIDTH != $clog2(DATA_WIDTH)) begin : g_bad_sft_width
    $error("SFT_WIDTH must equal $clog2(DATA_WIDTH)");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (DATA_WIDTH != CMD_DATA_WIDTH || SFT_WIDTH != CMD_SFT_WIDTH || TAG_WIDTH != CMD_TAG_WIDTH) begin : g_bad_cmd_width
    $error("widths must match the shared command type in shift_issue_stage_pkg");
  end

  shift_cmd_t              push_cmd, head_cmd;
  logic                    fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [DATA_WIDTH-1:0]   shift_res;
  logic [2*DATA_WIDTH-1:0] ror_wide;

  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;

  assign oRdy      = ~fifo_full;
  assign fifo_push = iVld & ~fifo_full;
  // Head moves into the output register whenever that register is free or draining
  assign fifo_pop  = ~fifo_empty & (~vld_q | iRdy);

  always_comb begin
    push_cmd.op     = sft_op_e'(iOp);
    push_cmd.dat    = iDat;
    push_cmd.sftBit = iSftBit;
    push_cmd.tag    = iTag;
  end

  shift_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (iFlush),
    .push     (fifo_push),
    .push_cmd (push_cmd),
    .pop      (fifo_pop),
    .head_cmd (head_cmd),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (oCnt)
  );

  always_comb begin
    ror_wide = {head_cmd.dat, head_cmd.dat} >> head_cmd.sftBit;
    case (head_cmd.op)
      SFT_SRL: shift_res = head_cmd.dat >> head_cmd.sftBit;
      SFT_SRA: shift_res = $signed(head_cmd.dat) >>> head_cmd.sftBit;
      SFT_SLL: shift_res = head_cmd.dat << head_cmd.sftBit;
      default: shift_res = ror_wide[DATA_WIDTH-1:0];
    endcase
  end

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    tag_d = tag_q;
    if (iFlush) begin
      vld_d = 1'b0;
    end else if (fifo_pop) begin
      vld_d = 1'b1;
      dat_d = shift_res;
      tag_d = head_cmd.tag;
    end else if (iRdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      tag_q <= tag_d;
    end
  end

  assign oVld = vld_q;
  assign oDat = dat_q;
  assign oTag = tag_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb/tb_shift_issue_stage.sv - randomized and directed bench for shift_issue_stage against a queue-level model
module tb_shift_issue_stage;

  localparam int DW    = 32;
  localparam int SW    = 5;
  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          rst, iFlush, iVld, oRdy, iRdy, oVld;
  logic [1:0]    iOp;
  logic [DW-1:0] iDat, oDat;
  logic [SW-1:0] iSftBit;
  logic [TW-1:0] iTag, oTag;
  logic [2:0]    oCnt;

  always #5 clk = ~clk;

  shift_issue_stage #(.DATA_WIDTH(DW), .SFT_WIDTH(SW), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .iFlush(iFlush), .iVld(iVld), .oRdy(oRdy),
    .iOp(iOp), .iDat(iDat), .iSftBit(iSftBit), .iTag(iTag),
    .oVld(oVld), .iRdy(iRdy), .oDat(oDat), .oTag(oTag), .oCnt(oCnt)
  );

  int tests_run = 0;
  int fails     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int s);
    logic [63:0] w;
    logic [63:0] sx;
    w  = {32'h0, d};
    sx = {{32{d[31]}}, d};
    case (op)
      2'd0:    return d >> s;
      2'd1:    return sx[31:0] >> s | ((sx >> s) & 64'hFFFF_FFFF);
      2'd2:    return 32'(w << s);
      default: return 32'((w >> s) | (w << (32 - s)));
    endcase
  endfunction

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
  } res_t;

  res_t        mq[$];
  res_t        nr, hd;
  bit          m_vld = 1'b0;
  logic [31:0] m_dat;
  logic [3:0]  m_tag;
  bit          acc;
  bit          chk_en = 1'b0;
  logic [3:0]  dut_tags[$];

  // Model: queue of pending results plus one output slot, updated per edge
  always @(posedge clk) begin
    if (rst || iFlush) begin
      mq.delete();
      m_vld = 1'b0;
    end else begin
      acc = iVld && (mq.size() < DEPTH);
      if (m_vld && iRdy) m_vld = 1'b0;
      if (!m_vld && mq.size() > 0) begin
        hd    = mq.pop_front();
        m_dat = hd.d;
        m_tag = hd.t;
        m_vld = 1'b1;
      end
      if (acc) begin
        nr.d = ref_shift(iOp, iDat, int'(iSftBit));
        nr.t = iTag;
        mq.push_back(nr);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("oVld", 32'(oVld), 32'(m_vld));
      check("oRdy", 32'(oRdy), 32'(mq.size() != DEPTH));
      check("oCnt", 32'(oCnt), 32'(mq.size()));
      if (m_vld) begin
        check("oDat", oDat, m_dat);
        check("oTag", 32'(oTag), 32'(m_tag));
      end
      if (oVld && iRdy) dut_tags.push_back(oTag);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s, input logic [3:0] t);
    iVld = 1'b1; iOp = op; iDat = d; iSftBit = s; iTag = t;
  endtask

  task automatic send_and_check(input string name, input logic [1:0] op, input logic [31:0] d,
                                input logic [4:0] s, input logic [3:0] t, input logic [31:0] exp);
    drive(op, d, s, t);
    step();
    iVld = 1'b0;
    check({name, "_vld_k"}, 32'(oVld), 32'd0);
    step();
    check({name, "_vld_k1"}, 32'(oVld), 32'd1);
    check({name, "_dat"}, oDat, exp);
    check({name, "_tag"}, 32'(oTag), 32'(t));
    step();
  endtask

  initial begin
    rst = 1'b1; iFlush = 1'b0; iVld = 1'b0; iRdy = 1'b1;
    iOp = 2'd0; iDat = '0; iSftBit = '0; iTag = '0;
    repeat (2) step();
    check("rst_oVld", 32'(oVld), 32'd0);
    check("rst_oCnt", 32'(oCnt), 32'd0);
    check("rst_oDat", oDat, 32'd0);
    check("rst_oTag", 32'(oTag), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    step();
    check("rst_oRdy", 32'(oRdy), 32'd1);

    send_and_check("sra", 2'd1, 32'h8000_0000, 5'd4, 4'd5, 32'hF800_0000);
    send_and_check("srl", 2'd0, 32'h8000_0000, 5'd4, 4'd9, 32'h0800_0000);
    send_and_check("ror1", 2'd3, 32'h0000_0001, 5'd1, 4'd3, 32'h8000_0000);
    send_and_check("sll31", 2'd2, 32'h0000_0001, 5'd31, 4'd7, 32'h8000_0000);
    for (int op = 0; op < 4; op++)
      send_and_check("zero_amt", 2'(op), 32'hDEAD_BEEF, 5'd0, 4'(op), 32'hDEAD_BEEF);
    send_and_check("ror8", 2'd3, 32'h1234_5678, 5'd8, 4'd1, 32'h7812_3456);

    // Fill output register plus the whole queue while downstream stalls
    iRdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 4'(i));
      step();
    end
    iVld = 1'b0;
    check("full_oCnt", 32'(oCnt), 32'd4);
    check("full_oRdy", 32'(oRdy), 32'd0);
    check("full_oVld", 32'(oVld), 32'd1);
    dut_tags.delete();
    iRdy = 1'b1;
    repeat (8) step();
    check("full_drain_count", 32'(dut_tags.size()), 32'd5);
    for (int i = 0; i < 5 && i < dut_tags.size(); i++)
      check("full_drain_order", 32'(dut_tags[i]), 32'(i));

    for (int i = 0; i < 16; i++) begin
      drive(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 4'(i));
      step();
      check("b2b_oVld", 32'(oVld), (i == 0) ? 32'd0 : 32'd1);
      check("b2b_cnt_le1", 32'(oCnt <= 3'd1), 32'd1);
    end
    iVld = 1'b0;
    repeat (4) step();

    iRdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(2'd0, $urandom, 5'd1, 4'(i));
      step();
    end
    check("preflush_oCnt", 32'(oCnt), 32'd3);
    check("preflush_oVld", 32'(oVld), 32'd1);
    iFlush = 1'b1;
    drive(2'd2, 32'h1, 5'd1, 4'd15);
    step();
    iFlush = 1'b0;
    iVld = 1'b0;
    check("flush_oVld", 32'(oVld), 32'd0);
    check("flush_oCnt", 32'(oCnt), 32'd0);
    check("flush_oRdy", 32'(oRdy), 32'd1);
    dut_tags.delete();
    iRdy = 1'b1;
    repeat (5) step();
    check("flush_nothing_out", 32'(dut_tags.size()), 32'd0);

    for (int c = 0; c < 1500; c++) begin
      iVld    = ($urandom_range(0, 3) != 0);
      iRdy    = ($urandom_range(0, 3) != 0);
      iFlush  = ($urandom_range(0, 59) == 0);
      rst     = ($urandom_range(0, 149) == 0);
      iOp     = 2'($urandom_range(0, 3));
      iDat    = $urandom;
      iSftBit = ($urandom_range(0, 5) == 0) ? 5'(31 * $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
      iTag    = 4'($urandom_range(0, 15));
      step();
    end
    rst = 1'b0; iFlush = 1'b0; iVld = 1'b0; iRdy = 1'b1;
    repeat (6) step();

    iRdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2'd1, $urandom, 5'd3, 4'(i + 8));
      step();
    end
    iVld = 1'b0;
    rst = 1'b1;
    dut_tags.delete();
    step();
    rst = 1'b0;
    iRdy = 1'b1;
    check("midrst_oVld", 32'(oVld), 32'd0);
    check("midrst_oCnt", 32'(oCnt), 32'd0);
    check("midrst_oDat", oDat, 32'd0);
    send_and_check("post_rst", 2'd0, 32'hF000_000F, 5'd4, 4'd6, 32'h0F00_0000);
    check("midrst_only_fresh", 32'(dut_tags.size()), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
SHIFT_ISSUE_STAGE -- requirements
Module: shift_issue_stage

Interface
- REQ-001 Parameter DATA_WIDTH, default 32, shift datapath width in bits.
- REQ-002 Parameter SFT_WIDTH, default 5, shift-amount width in bits.
- REQ-003 Parameter DEPTH, default 4, command-queue depth in entries; power of two, >= 2.
- REQ-004 Parameter TAG_WIDTH, default 4, width of the caller tag carried alongside each command.
- REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
- REQ-006 rst  input  1  reset, synchronous and active-high.
- REQ-007 iFlush  input  1  synchronous flush; discards all queued and registered commands.
- REQ-008 iVld  input  1  upstream command valid.
- REQ-009 oRdy  output  1  stage can accept a command this cycle.
- REQ-010 iOp  input  2  shift type: 00 SRL, 01 SRA, 10 SLL, 11 ROR (rotate right).
- REQ-011 iDat  input  DATA_WIDTH  operand.
- REQ-012 iSftBit  input  SFT_WIDTH  shift amount.
- REQ-013 iTag  input  TAG_WIDTH  caller tag, returned unchanged with the result.
- REQ-014 oVld  output  1  result valid.
- REQ-015 iRdy  input  1  downstream accepts the result.
- REQ-016 oDat  output  DATA_WIDTH  shift result.
- REQ-017 oTag  output  TAG_WIDTH  tag of the command that produced oDat.
- REQ-018 oCnt  output  $clog2(DEPTH)+1  current queue occupancy, 0..DEPTH.

Function
- REQ-019 Transfer in: iVld & oRdy on a rising edge writes {iOp,iDat,iSftBit,iTag} at the queue tail.
- REQ-020 oRdy SHALL equal (oCnt != DEPTH) and SHALL NOT depend combinationally on iVld.
- REQ-021 Transfer out: oVld & iRdy on a rising edge retires the output register.
- REQ-022 The output register loads the queue-head result when the queue is non-empty and (!oVld | iRdy); the load pops the head in the same edge.
- REQ-023 Latency: a command accepted at edge k into an empty queue with an empty output register SHALL present oVld=1 after edge k+1.
- REQ-024 Throughput: one command per cycle sustained while iRdy=1; results retire in acceptance order.
- REQ-025 Push and pop on the same edge SHALL leave oCnt unchanged; push into a full queue is not possible (oRdy=0), pop from empty is a no-op.
- REQ-026 Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- REQ-027 SRL: logical right shift, zero fill.
- REQ-028 SRA: arithmetic right shift, fill with iDat[DATA_WIDTH-1].
- REQ-029 SLL: logical left shift, zero fill.
- REQ-030 ROR: rotate right by iSftBit modulo DATA_WIDTH.
- REQ-031 Shift amount 0 SHALL return iDat unchanged for all four types.
- REQ-032 oDat and oTag SHALL hold stable while oVld=1 and iRdy=0.
- REQ-033 iFlush=1 SHALL empty the queue, clear oVld and zero oCnt at the edge; a concurrent push is dropped; flush takes priority over every push and pop.
- REQ-034 Elaboration SHALL fail with an error if SFT_WIDTH != $clog2(DATA_WIDTH) or DEPTH is not a power of two >= 2.

Reset
- REQ-035 rst=1 at a rising edge SHALL force oVld=0, oCnt=0, both pointers 0, oDat=0, oTag=0; oRdy=1 in the first cycle after release.
- REQ-036 Reset asserted mid-stream SHALL discard all in-flight commands without emitting any result; queue storage contents need not be cleared.

Structure
- REQ-037 A shared package SHALL hold the op-code enum (SFT_SRL, SFT_SRA, SFT_SLL, SFT_ROR) and the command struct typedef {op, dat, sftBit, tag}.
- REQ-038 The queue SHALL be a separate sub-module shift_cmd_fifo (push/pop, full/empty, count); decode, shift and the output register live in shift_issue_stage.

Verification
- REQ-039 DATA_WIDTH=32: SRA of 0x8000_0000 by 4 -> oDat 0xF800_0000; SRL same operands -> 0x0800_0000; tag returned unchanged.
- REQ-040 ROR 0x0000_0001 by 1 -> 0x8000_0000; SLL 0x0000_0001 by 31 -> 0x8000_0000; any op by 0 -> operand unchanged.
- REQ-041 Hold iRdy=0, push 5 commands with DEPTH=4 -> 1 in output register, 4 queued, oCnt=4, oRdy=0; release iRdy -> 5 results in order with tags 0..4.
- REQ-042 Back-to-back push with iRdy=1 for 16 cycles -> oVld first high after the 2nd edge, then one result per cycle, oCnt stays <= 1.
- REQ-043 Queue at 3 entries, oVld=1, assert iFlush with iVld=1 -> next cycle oVld=0, oCnt=0, oRdy=1, dropped command never appears.
- REQ-044 Assert rst for one cycle mid-stream -> oVld=0, oCnt=0, oDat=0; a fresh command after release completes with 2-cycle latency.
